// File: rtl/reset_sequencer.sv
// Staged reset-release sequencer: per-stage delay, ready handshake with timeout, fault supervision.
// Define RSEQ_REVERSE_SHUTDOWN_EN for a staged high-to-low stage_en teardown on fault.
`timescale 1ns/1ps
module reset_sequencer #(
   parameter int unsigned NUM_STAGES  = 4,
   parameter logic [31:0] STAGE_DELAY = 32'd80000,
   parameter logic [31:0] TIMEOUT     = 32'd800000,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  fault_clear,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  all_up,
   output logic                  busy,
   output logic                  fault,
   output logic [2:0]            fault_stage
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DELAY    = 3'd1,
      S_WAIT_RDY = 3'd2,
      S_UP       = 3'd3,
      S_FAULT    = 3'd4
   } state_t;

   localparam logic [NUM_STAGES-1:0] ZERO_EN = {NUM_STAGES{1'b0}};
   localparam logic [2:0]            LAST_IDX = 3'(NUM_STAGES - 1);

   state_t                  state_r;
   logic [31:0]             cnt_r;
   logic [2:0]              idx_r;
   logic                    auto_pend_r;

   logic [31:0]             cnt_inc_s;
   logic [NUM_STAGES-1:0]   sel_s;
   logic [NUM_STAGES-1:0]   drop_s;
   logic [NUM_STAGES-1:0]   lost_s;
   logic                    ready_s;
   logic                    last_s;
   logic                    fault_hit_s;
   logic [2:0]              fault_idx_s;
   logic [NUM_STAGES-1:0]   en_fault_s;
   logic                    busy_fault_s;

   function automatic logic [NUM_STAGES-1:0] onehot(input logic [2:0] idx);
      logic [NUM_STAGES-1:0] m;
      for (int i = 0; i < NUM_STAGES; i++) m[i] = (3'(i) == idx);
      return m;
   endfunction

   function automatic logic [NUM_STAGES-1:0] below_mask(input logic [2:0] idx);
      logic [NUM_STAGES-1:0] m;
      for (int i = 0; i < NUM_STAGES; i++) m[i] = (3'(i) < idx);
      return m;
   endfunction

   function automatic logic [2:0] lowest_set(input logic [NUM_STAGES-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) r = v[i] ? 3'(i) : r;
      return r;
   endfunction

   function automatic logic [2:0] highest_set(input logic [NUM_STAGES-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < NUM_STAGES; i++) r = v[i] ? 3'(i) : r;
      return r;
   endfunction

   // Datapath helpers: saturating count, stage select, supervision masks, fault-entry enables
   always_comb begin
      cnt_inc_s = (cnt_r == 32'hFFFF_FFFF) ? cnt_r : (cnt_r + 32'd1);
      sel_s     = onehot(idx_r);
      ready_s   = |(stage_ready & sel_s);
      last_s    = (idx_r == LAST_IDX);
      drop_s    = below_mask(idx_r) & ~stage_ready;
      lost_s    = ~stage_ready;
`ifdef RSEQ_REVERSE_SHUTDOWN_EN
      en_fault_s   = stage_en & ~onehot(highest_set(stage_en));
      busy_fault_s = (en_fault_s != ZERO_EN);
`else
      en_fault_s   = ZERO_EN;
      busy_fault_s = 1'b0;
`endif
   end

   // Fault detection; a ready on the stage being waited on beats its timeout
   always_comb begin
      fault_hit_s = 1'b0;
      fault_idx_s = 3'd0;
      case (state_r)
         S_DELAY: begin
            if (drop_s != ZERO_EN) begin
               fault_hit_s = 1'b1;
               fault_idx_s = lowest_set(drop_s);
            end else begin
               fault_hit_s = 1'b0;
            end
         end
         S_WAIT_RDY: begin
            if (drop_s != ZERO_EN) begin
               fault_hit_s = 1'b1;
               fault_idx_s = lowest_set(drop_s);
            end else if (ready_s) begin
               fault_hit_s = 1'b0;
            end else if (cnt_inc_s >= TIMEOUT) begin
               fault_hit_s = 1'b1;
               fault_idx_s = idx_r;
            end else begin
               fault_hit_s = 1'b0;
            end
         end
         S_UP: begin
            if (lost_s != ZERO_EN) begin
               fault_hit_s = 1'b1;
               fault_idx_s = lowest_set(lost_s);
            end else begin
               fault_hit_s = 1'b0;
            end
         end
         default: begin
            fault_hit_s = 1'b0;
            fault_idx_s = 3'd0;
         end
      endcase
   end

   // Sequencer state machine with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         cnt_r       <= 32'd0;
         idx_r       <= 3'd0;
         auto_pend_r <= AUTO_START;
         stage_en    <= ZERO_EN;
         all_up      <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
         fault_stage <= 3'd0;
      end else if (fault_hit_s) begin
         state_r     <= S_FAULT;
         cnt_r       <= 32'd0;
         stage_en    <= en_fault_s;
         busy        <= busy_fault_s;
         all_up      <= 1'b0;
         fault       <= 1'b1;
         fault_stage <= fault_idx_s;
      end else begin
         case (state_r)
            S_IDLE: begin
               all_up <= 1'b0;
               busy   <= 1'b0;
               if (start || auto_pend_r) begin
                  state_r     <= S_DELAY;
                  idx_r       <= 3'd0;
                  cnt_r       <= 32'd0;
                  busy        <= 1'b1;
                  auto_pend_r <= 1'b0;
               end
            end
            S_DELAY: begin
               if (cnt_r == STAGE_DELAY) begin
                  stage_en <= stage_en | sel_s;
                  cnt_r    <= 32'd0;
                  state_r  <= S_WAIT_RDY;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            S_WAIT_RDY: begin
               if (ready_s) begin
                  if (last_s) begin
                     state_r <= S_UP;
                  end else begin
                     idx_r   <= idx_r + 3'd1;
                     cnt_r   <= 32'd0;
                     state_r <= S_DELAY;
                  end
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            S_UP: begin
               all_up <= 1'b1;
               busy   <= 1'b0;
            end
            S_FAULT: begin
`ifdef RSEQ_REVERSE_SHUTDOWN_EN
               if (stage_en != ZERO_EN) begin
                  if (cnt_inc_s >= STAGE_DELAY) begin
                     stage_en <= en_fault_s;
                     busy     <= busy_fault_s;
                     cnt_r    <= 32'd0;
                  end else begin
                     cnt_r <= cnt_inc_s;
                  end
               end else if (fault_clear) begin
                  state_r <= S_IDLE;
                  fault   <= 1'b0;
                  busy    <= 1'b0;
               end
`else
               if (fault_clear) begin
                  state_r <= S_IDLE;
                  fault   <= 1'b0;
               end
`endif
            end
            default: begin
               state_r  <= S_IDLE;
               stage_en <= ZERO_EN;
               busy     <= 1'b0;
               all_up   <= 1'b0;
            end
         endcase
      end
   end

endmodule
